ept_xlate: RTL

//   Second-generation EPT translator: guest-physical -> host-physical per VMID.

---
 rtl/ept_pkg.sv | 31 +++
 rtl/ept_tlb.sv | 101 ++++++++++
 rtl/ept_xlate.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ept_pkg.sv
// Shared types and helpers for the EPT translator.
package ept_pkg;

  localparam int PA_W       = 64;
  localparam int PAGE_SHIFT = 12;
  localparam int GPN_W      = PA_W - PAGE_SHIFT;
  localparam int VMID_W_DEF = 4;

  localparam logic [PA_W-1:0] OFS_MASK = {{GPN_W{1'b0}}, {PAGE_SHIFT{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WALK,
    S_RESP
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [VMID_W_DEF-1:0] vmid;
    logic [GPN_W-1:0]      gpn;
    logic [GPN_W-1:0]      hpn;
  } tlb_entry_t;

  // Page number is XORed with the key, page offset passes through.
  function automatic logic [PA_W-1:0] xlate(input logic [PA_W-1:0] gpa,
                                            input logic [PA_W-1:0] key);
    return gpa ^ (key & ~OFS_MASK);
  endfunction

endpackage

// File: rtl/ept_tlb.sv
// Fully-associative translation cache: CAM lookup, fill with
// first-free / round-robin victim, and per-VMID or global invalidation.
module ept_tlb
  import ept_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int VMID_W  = 4,
  parameter int GPN_W_P = 52
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VMID_W-1:0]  lk_vmid,
  input  logic [GPN_W_P-1:0] lk_gpn,
  output logic               lk_hit,
  output logic [GPN_W_P-1:0] lk_hpn,
  input  logic               fill_en,
  input  logic [VMID_W-1:0]  fill_vmid,
  input  logic [GPN_W_P-1:0] fill_gpn,
  input  logic [GPN_W_P-1:0] fill_hpn,
  input  logic               inv_en,
  input  logic               inv_all,
  input  logic [VMID_W-1:0]  inv_vmid,
  input  logic               cfg_inv_en,
  input  logic [VMID_W-1:0]  cfg_inv_vmid
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [VMID_W-1:0]  vmid_q [ENTRIES];
  logic [GPN_W_P-1:0] gpn_q  [ENTRIES];
  logic [GPN_W_P-1:0] hpn_q  [ENTRIES];
  logic [IDX_W-1:0]   rr;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   fill_idx;
  logic               has_free;
  logic [ENTRIES-1:0] kill;

  // CAM match on (vmid, gpn)
  always_comb begin
    lk_hit = 1'b0;
    lk_hpn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && vmid_q[i] == lk_vmid && gpn_q[i] == lk_gpn) begin
        lk_hit = 1'b1;
        lk_hpn = hpn_q[i];
      end
    end
  end

  // Victim choice: lowest invalid entry, else the round-robin pointer
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    fill_idx = has_free ? free_idx : rr;
  end

  // Invalidate mask; an entry being filled this edge is judged by its new vmid
  always_comb begin
    logic [VMID_W-1:0] ev;
    ev   = '0;
    kill = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ev = (fill_en && fill_idx == IDX_W'(i)) ? fill_vmid : vmid_q[i];
      kill[i] = (inv_en && (inv_all || ev == inv_vmid)) ||
                (cfg_inv_en && ev == cfg_inv_vmid);
    end
  end

  // Valid bits and victim pointer; invalidation overrides a same-edge fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      rr    <= '0;
    end else begin
      if (fill_en) begin
        valid[fill_idx] <= 1'b1;
        if (!has_free) rr <= rr + IDX_W'(1);
      end
      for (int i = 0; i < ENTRIES; i++) begin
        if (kill[i]) valid[i] <= 1'b0;
      end
    end
  end

  // Entry payload; only meaningful while the valid bit is set
  always_ff @(posedge clk) begin
    if (fill_en) begin
      vmid_q[fill_idx] <= fill_vmid;
      gpn_q[fill_idx]  <= fill_gpn;
      hpn_q[fill_idx]  <= fill_hpn;
    end
  end

endmodule

// File: rtl/ept_xlate.sv
// Guest-physical to host-physical translator with per-VM config,
// TLB, fixed-latency miss walk and perf counters.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_IDLE   | ready for a request
//   S_LOOKUP | two cycles: sample cfg + TLB, then decide fault/hit/miss
//   S_WALK   | miss walk, down-counter to zero, then recompute and fill
//   S_RESP   | response held until consumer handshake
module ept_xlate
  import ept_pkg::*;
#(
  parameter int NUM_VM      = 16,
  parameter int TLB_ENTRIES = 8,
  parameter int MISS_LAT    = 4,
  parameter int VMID_W      = $clog2(NUM_VM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we_i,
  input  logic [VMID_W-1:0] cfg_vmid_i,
  input  logic              cfg_en_i,
  input  logic [PA_W-1:0]   cfg_key_i,
  input  logic [PA_W-1:0]   cfg_limit_i,
  input  logic              inv_valid_i,
  input  logic              inv_all_i,
  input  logic [VMID_W-1:0] inv_vmid_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [VMID_W-1:0] req_vmid_i,
  input  logic [PA_W-1:0]   req_gpa_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [PA_W-1:0]   resp_hpa_o,
  output logic              resp_fault_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int CNT_W = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;
  localparam logic [VMID_W:0] NUM_VM_L = (VMID_W + 1)'(NUM_VM);

  state_e            state, state_nxt;
  logic              lk_phase;
  logic [VMID_W-1:0] req_vmid_q;
  logic [PA_W-1:0]   req_gpa_q;
  logic              lk_fault, lk_hit;
  logic [GPN_W-1:0]  lk_hpn;
  logic [CNT_W-1:0]  walk_cnt;
  logic              stale;

  logic              cfg_en    [NUM_VM];
  logic [PA_W-1:0]   cfg_key   [NUM_VM];
  logic [PA_W-1:0]   cfg_limit [NUM_VM];

  logic              tlb_hit;
  logic [GPN_W-1:0]  tlb_hpn;
  logic              accept, decide, walk_done, inv_match, fill_en;
  logic              vm_ok, vm_en, cur_fault;
  logic [PA_W-1:0]   vm_key, vm_limit, cur_hpa;

  assign req_ready_o = rst_n && (state == S_IDLE);
  assign accept      = req_ready_o && req_valid_i;
  assign decide      = (state == S_LOOKUP) && lk_phase;
  assign walk_done   = (state == S_WALK) && (walk_cnt == '0);
  assign inv_match   = (inv_valid_i && (inv_all_i || inv_vmid_i == req_vmid_q)) ||
                       (cfg_we_i && cfg_vmid_i == req_vmid_q);
  assign fill_en     = walk_done && !cur_fault && !stale && !inv_match;

  // Current config of the captured VMID and the translation it implies
  always_comb begin
    vm_ok    = ({1'b0, req_vmid_q} < NUM_VM_L);
    vm_en    = 1'b0;
    vm_key   = '0;
    vm_limit = '0;
    if (vm_ok) begin
      vm_en    = cfg_en[req_vmid_q];
      vm_key   = cfg_key[req_vmid_q];
      vm_limit = cfg_limit[req_vmid_q];
    end
    cur_fault = !vm_en || (req_gpa_q >= vm_limit);
    cur_hpa   = xlate(req_gpa_q, vm_key);
  end

  // Per-VM configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VM; i++) begin
        cfg_en[i]    <= 1'b0;
        cfg_key[i]   <= '0;
        cfg_limit[i] <= '0;
      end
    end else if (cfg_we_i && ({1'b0, cfg_vmid_i} < NUM_VM_L)) begin
      cfg_en[cfg_vmid_i]    <= cfg_en_i;
      cfg_key[cfg_vmid_i]   <= cfg_key_i;
      cfg_limit[cfg_vmid_i] <= cfg_limit_i;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LOOKUP;
      S_LOOKUP: if (lk_phase) state_nxt = (lk_fault || lk_hit) ? S_RESP : S_WALK;
      S_WALK:   if (walk_cnt == '0) state_nxt = S_RESP;
      S_RESP:   if (resp_ready_i) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request capture, lookup sampling, walk timer, response and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_vmid_q   <= '0;
      req_gpa_q    <= '0;
      lk_phase     <= 1'b0;
      lk_fault     <= 1'b0;
      lk_hit       <= 1'b0;
      lk_hpn       <= '0;
      walk_cnt     <= '0;
      stale        <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_hpa_o   <= '0;
      resp_fault_o <= 1'b0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
    end else begin
      if (accept) begin
        req_vmid_q <= req_vmid_i;
        req_gpa_q  <= req_gpa_i;
        lk_phase   <= 1'b0;
        stale      <= 1'b0;
      end
      if (state == S_LOOKUP && !lk_phase) begin
        lk_phase <= 1'b1;
        lk_fault <= cur_fault;
        lk_hit   <= tlb_hit;
        lk_hpn   <= tlb_hpn;
      end
      if ((state == S_LOOKUP || state == S_WALK) && inv_match) stale <= 1'b1;
      if (decide) begin
        if (lk_fault) begin
          resp_valid_o <= 1'b1;
          resp_fault_o <= 1'b1;
          resp_hpa_o   <= '0;
        end else if (lk_hit) begin
          resp_valid_o <= 1'b1;
          resp_fault_o <= 1'b0;
          resp_hpa_o   <= {lk_hpn, req_gpa_q[PAGE_SHIFT-1:0]};
          if (hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
        end else begin
          walk_cnt <= CNT_W'(MISS_LAT - 1);
          if (miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
      end
      if (state == S_WALK) begin
        if (walk_cnt != '0) begin
          walk_cnt <= walk_cnt - CNT_W'(1);
        end else begin
          resp_valid_o <= 1'b1;
          resp_fault_o <= cur_fault;
          resp_hpa_o   <= cur_fault ? '0 : cur_hpa;
        end
      end
      if (state == S_RESP && resp_ready_i) resp_valid_o <= 1'b0;
    end
  end

  ept_tlb #(
    .ENTRIES (TLB_ENTRIES),
    .VMID_W  (VMID_W),
    .GPN_W_P (GPN_W)
  ) u_tlb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lk_vmid      (req_vmid_q),
    .lk_gpn       (req_gpa_q[PA_W-1:PAGE_SHIFT]),
    .lk_hit       (tlb_hit),
    .lk_hpn       (tlb_hpn),
    .fill_en      (fill_en),
    .fill_vmid    (req_vmid_q),
    .fill_gpn     (req_gpa_q[PA_W-1:PAGE_SHIFT]),
    .fill_hpn     (cur_hpa[PA_W-1:PAGE_SHIFT]),
    .inv_en       (inv_valid_i),
    .inv_all      (inv_all_i),
    .inv_vmid     (inv_vmid_i),
    .cfg_inv_en   (cfg_we_i),
    .cfg_inv_vmid (cfg_vmid_i)
  );

endmodule
